// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: default sizes,
// FSM state encoding and a small width helper.
package uart_tx_arbiter_pkg;

  localparam int N_REQ_DEF     = 3;
  localparam int DATA_BITS_DEF = 8;
  localparam int MAX_BURST_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Width of a counter that must hold values 0..max_burst.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the uart_tx core.
// The master side is the requesters plus the transmitter's ready.
// The slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ     = 3,
  parameter int DATA_BITS = 8
);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_last;
  logic [N_REQ*DATA_BITS-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic [DATA_BITS-1:0]       tx_data;
  logic                       tx_valid;
  logic                       tx_ready;

  modport master (
    output req_valid, req_last, req_data, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_last, req_data, tx_ready,
    output req_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick.
// Scans the request vector starting one past the previous owner, wrapping
// modulo N_REQ, and returns the first requester found.
// Purely combinational so it can be exercised on its own.
module rr_pick #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_owner,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any_req
);

  localparam int IDX_W = $clog2(N_REQ);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Priority scan, lowest rotation distance from last_owner wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last_owner) + k) % N_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx core among N_REQ byte-stream requesters.
// A grant is packet-locked: the owner keeps the transmitter until it sends a
// byte flagged last, or until MAX_BURST bytes have gone out. Either way, one
// IDLE cycle follows, and in it the next owner is picked round-robin.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no owner; pick the next owner if any req_valid is high; no bytes move
// OWN   | owner's valid/data forwarded to tx, tx_ready returned as its ready
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_arbiter_if.slave     bus,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy
);

  localparam int                IDX_W     = $clog2(N_REQ);
  localparam int                CNT_W     = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  OWNER_RST = IDX_W'(N_REQ - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;

  logic [IDX_W-1:0]     winner;
  logic                 any_req;
  logic                 handshake;
  logic                 valid_c;
  logic [DATA_BITS-1:0] data_c;
  logic [N_REQ-1:0]     ready_c;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req        (bus.req_valid),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // State, ownership and burst bookkeeping registers. last_owner resets to
  // the top index so that requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OWNER_RST;
      grant_q      <= '0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Next-state and forwarding logic. Outputs are derived only from registered
  // state, so an asynchronous reset clears them immediately.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    burst_cnt_d  = burst_cnt_q;
    valid_c      = 1'b0;
    data_c       = '0;
    ready_c      = '0;
    handshake    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = OWN;
          owner_d     = winner;
          grant_d     = N_REQ'(1) << winner;
          burst_cnt_d = '0;
        end
      end

      OWN: begin
        valid_c          = bus.req_valid[owner_q];
        data_c           = bus.req_data[int'(owner_q)*DATA_BITS +: DATA_BITS];
        ready_c[owner_q] = bus.tx_ready;
        handshake        = valid_c & bus.tx_ready;
        if (handshake) begin
          if (bus.req_last[owner_q] || (burst_cnt_q == CNT_LAST)) begin
            // Release even mid-packet at the burst limit. The remainder of
            // the packet waits for a later grant, so no byte is lost.
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
            burst_cnt_d  = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant         = grant_q;
  assign busy          = (state_q == OWN);
  assign bus.tx_valid  = valid_c;
  assign bus.tx_data   = data_c;
  assign bus.req_ready = ready_c;

  // Ownership is exclusive: at most one grant, and ready only towards it.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant_q));

  a_ready_owner_only : assert property (@(posedge clk) disable iff (!rst)
    (ready_c & ~grant_q) == '0);

  a_burst_bound : assert property (@(posedge clk) disable iff (!rst)
    burst_cnt_q < CNT_W'(MAX_BURST));

  a_idle_no_grant : assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE) |-> (grant_q == '0));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against a behavioural owner/queue model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] grant;
  logic         busy;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_BITS(DW)) bus ();

  uart_tx_arbiter #(
    .N_REQ     (N),
    .DATA_BITS (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending bytes per requester, {last, data}.
  logic [8:0]    rq [N][$];
  logic [DW-1:0] exp_stream [N][$];
  logic [DW-1:0] tx_log [$];
  int            src_log [$];
  int            hs_cyc [$];

  // Behavioural model: current owner (-1 when none), previous owner and bytes
  // sent under the current grant.
  int owner      = -1;
  int last_owner = N - 1;
  int cnt        = 0;
  int cyc        = 0;

  int rand_valid = 0;
  int ready_mode = 0;   // 0: ready high, 1: random, 2: ready low

  logic [N-1:0]    drv_valid;
  logic            drv_ready;
  logic [N*DW-1:0] drv_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pending();
    int t = 0;
    for (int i = 0; i < N; i++) t += rq[i].size();
    return t;
  endfunction

  task automatic clear_inputs();
    drv_valid     = '0;
    drv_ready     = 1'b0;
    drv_data      = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    src_log.delete();
    hs_cyc.delete();
  endtask

  task automatic drive_inputs();
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        d[i*DW +: DW] = rq[i][0][7:0];
        if (rand_valid == 0 || $urandom_range(0, 3) != 0) begin
          v[i] = 1'b1;
          l[i] = rq[i][0][8];
        end
      end
    end
    drv_valid = v;
    drv_data  = d;
    if (ready_mode == 0)      drv_ready = 1'b1;
    else if (ready_mode == 1) drv_ready = 1'($urandom_range(0, 1));
    else                      drv_ready = 1'b0;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.tx_ready  = drv_ready;
  endtask

  task automatic check_outputs();
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic          ev;
    logic [DW-1:0] ed;
    eg = '0;
    er = '0;
    ev = 1'b0;
    ed = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ev        = drv_valid[owner];
      ed        = drv_data[owner*DW +: DW];
      er[owner] = drv_ready;
    end
    check_eq("grant",     grant,         eg);
    check_eq("busy",      busy,          owner >= 0);
    check_eq("tx_valid",  bus.tx_valid,  ev);
    check_eq("tx_data",   bus.tx_data,   ed);
    check_eq("req_ready", bus.req_ready, er);
  endtask

  task automatic model_update();
    logic [8:0] e;
    int         c;
    int         found;
    if (owner >= 0) begin
      if (drv_valid[owner] && drv_ready) begin
        e = rq[owner].pop_front();
        tx_log.push_back(e[7:0]);
        src_log.push_back(owner);
        hs_cyc.push_back(cyc);
        if (e[8] || cnt == MB - 1) begin
          last_owner = owner;
          owner      = -1;
          cnt        = 0;
        end else begin
          cnt++;
        end
      end
    end else begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (last_owner + k) % N;
        if (found == 0 && drv_valid[c]) begin
          owner = c;
          cnt   = 0;
          found = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_inputs();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (pending() > 0 && n < bound) begin
      cycle();
      n++;
    end
    check_eq("drain_timeout", n >= bound, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      exp_stream[i].delete();
    end
    clear_logs();
    owner      = -1;
    last_owner = N - 1;
    cnt        = 0;
    rand_valid = 0;
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_grant",     grant,         0);
    check_eq("rst_busy",      busy,          0);
    check_eq("rst_tx_valid",  bus.tx_valid,  0);
    check_eq("rst_tx_data",   bus.tx_data,   0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    rst = 1'b1;
  endtask

  task automatic push_pkt(input int r, input int first, input int len);
    for (int j = 0; j < len; j++)
      rq[r].push_back({(j == len - 1), 8'(first + j)});
  endtask

  // Compare the transmitted byte log with up to 8 bytes packed MSB first.
  task automatic check_log(input string tag, input logic [63:0] bytes, input int n);
    check_eq({tag, "_len"}, tx_log.size(), n);
    for (int k = 0; k < n && k < tx_log.size(); k++)
      check_eq(tag, tx_log[k], bytes[63-8*k -: 8]);
  endtask

  task automatic random_round();
    int         npk;
    int         len;
    int         b;
    int         s;
    logic [8:0] e;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      npk = $urandom_range(1, 5);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) begin
          b = $urandom_range(0, 255);
          e = {(j == len - 1), 8'(b)};
          rq[i].push_back(e);
          exp_stream[i].push_back(8'(b));
        end
      end
    end
    rand_valid = 1;
    ready_mode = 1;
    drain(3000);
    for (int k = 0; k < tx_log.size(); k++) begin
      s = src_log[k];
      check_eq("rand_src_has_bytes", exp_stream[s].size() > 0, 1);
      if (exp_stream[s].size() > 0)
        check_eq("rand_order", tx_log[k], exp_stream[s].pop_front());
    end
    for (int i = 0; i < N; i++) check_eq("rand_left", exp_stream[i].size(), 0);
    rand_valid = 0;
    ready_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #2;
    reset_dut();

    // All three requesters with 1-byte packets: strict rotation, one byte
    // every two cycles.
    for (int i = 0; i < N; i++) begin
      push_pkt(i, 8'h20 + i, 1);
      push_pkt(i, 8'h30 + i, 1);
    end
    drain(100);
    check_eq("rr_count", src_log.size(), 6);
    for (int k = 0; k < src_log.size(); k++) check_eq("rr_order", src_log[k], k % N);
    for (int k = 1; k < hs_cyc.size(); k++) check_eq("rr_gap", hs_cyc[k] - hs_cyc[k-1], 2);

    // Packet lock: requester 2 waits for requester 1's 3-byte packet.
    reset_dut();
    push_pkt(1, 8'hA1, 3);
    push_pkt(2, 8'hC0, 1);
    drain(100);
    check_log("pkt_lock", 64'hA1A2A3C0_00000000, 4);

    // Forced release after MAX_BURST bytes; requester 1 slips in.
    reset_dut();
    push_pkt(0, 8'h10, 6);
    push_pkt(1, 8'h99, 1);
    drain(100);
    check_log("burst", 64'h10111213_99141500, 7);

    // Transmitter stall mid-burst must not advance the burst count.
    reset_dut();
    push_pkt(0, 8'h50, 5);
    push_pkt(1, 8'h77, 1);
    repeat (3) cycle();
    ready_mode = 2;
    repeat (10) cycle();
    ready_mode = 0;
    drain(100);
    check_log("stall", 64'h50515253_77540000, 6);

    // Asynchronous reset while requester 2 owns the transmitter.
    reset_dut();
    push_pkt(0, 8'h5F, 1);
    push_pkt(2, 8'h60, 5);
    repeat (5) cycle();
    check_eq("pre_rst_grant", grant, 3'b100);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_grant",     grant,         0);
    check_eq("async_busy",      busy,          0);
    check_eq("async_tx_valid",  bus.tx_valid,  0);
    check_eq("async_req_ready", bus.req_ready, 0);
    reset_dut();
    push_pkt(1, 8'h02, 1);
    push_pkt(0, 8'h01, 1);
    drain(100);
    check_log("post_rst", 64'h0102_0000_0000_0000, 2);

    // Lone requester, back-to-back packets: exactly one idle cycle between.
    reset_dut();
    push_pkt(2, 8'hB1, 1);
    push_pkt(2, 8'hB2, 1);
    drain(100);
    check_log("b2b", 64'hB1B2_0000_0000_0000, 2);
    check_eq("b2b_hs_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) check_eq("b2b_gap", hs_cyc[1] - hs_cyc[0], 2);

    // Randomized traffic with random valid gaps and transmitter back-pressure.
    reset_dut();
    for (int r = 0; r < 4; r++) random_round();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter core among N byte-stream requesters, e.g. debug console, status reporter and command-response path.
- Grants are packet-locked: a winner keeps the transmitter until it presents a byte flagged last, or until it has sent MAX_BURST bytes. This bounds starvation.
- Sits between the requesters and the existing uart_tx core's valid/ready byte interface.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DATA_BITS, 8, byte width forwarded to the transmitter.
- MAX_BURST, 16, maximum bytes per grant before forced re-arbitration (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester byte valid.
- req_last  input  N_REQ  per-requester end-of-packet flag, qualified by req_valid.
- req_data  input  N_REQ*DATA_BITS  packed bytes; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- tx_data  output  DATA_BITS  byte to the UART transmitter.
- tx_valid  output  1  byte valid to the transmitter.
- tx_ready  input  1  transmitter can accept a byte (idle).
- grant  output  N_REQ  one-hot current owner; all zero when idle.
- busy  output  1  high in state OWN.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, grant=0, busy=0.
  - tx_valid=0, tx_data=0, req_ready=0.
  - burst_cnt=0, last_owner=N_REQ-1, so requester 0 wins first.
- State IDLE:
  - If any req_valid is high, pick the first valid index scanning last_owner+1, last_owner+2, ... with wrap modulo N_REQ.
  - On that clk edge: grant<=onehot(winner), state<=OWN, burst_cnt<=0.
  - No bytes move in IDLE. Arbitration latency is exactly 1 cycle from req_valid to grant.
- State OWN (owner o):
  - Combinational forwarding:
    - tx_valid = req_valid[o].
    - tx_data = req_data[o].
    - req_ready[o] = tx_ready.
    - All other req_ready bits are 0.
  - Handshake = tx_valid & tx_ready. On a handshake:
    - If req_last[o], or burst_cnt == MAX_BURST-1: state<=IDLE, grant<=0, last_owner<=o, burst_cnt<=0.
    - Otherwise burst_cnt<=burst_cnt+1.
  - Owner dropping req_valid mid-packet: grant is held indefinitely; tx_valid follows and goes low. No timeout.
  - When the owner is the only requester, back-to-back packets from it have exactly one IDLE cycle between its last byte and its next first byte.
- Forced release at MAX_BURST:
  - The packet continues under a later grant. No bytes are lost or reordered within a requester.
  - With several requesters active, another requester is served before the remainder.
- Width rule: burst_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
- Simultaneous events:
  - A handshake with last, coinciding with new req_valid bits, is resolved in the following IDLE cycle.
  - The IDLE cycle is never skipped, so round-robin order is updated before the pick.
- Reset mid-packet: outputs clear asynchronously, the partial byte stream is abandoned, and requester 0 has priority after release.
- grant is always one-hot or zero. req_ready must never be high for a non-owner.

Decomposition:
- uart_pkg: DATA_BITS default constant, and state typedef enum {IDLE, OWN}.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: req vector, last_owner index.
  - Outputs: winner index and any_req.
  - Holds the rotate and priority-encode logic so it can be unit-tested alone.

Test Plan:
- Reset then req_valid=3'b111, every requester sending 1-byte packets with last=1, tx_ready always 1 -> grants in order 0,1,2,0; one byte forwarded every 2 cycles.
- Requester 1 sends 3-byte packet 0xA1,0xA2,0xA3 with last on 0xA3, while requester 2 is valid throughout -> tx_data sequence A1,A2,A3, then requester 2's byte; grant never changes mid-packet.
- MAX_BURST=4, requester 0 sends 6 bytes 0x10..0x15 with no last until 0x15, requester 1 sends single byte 0x99 -> tx sequence 10,11,12,13,99,14,15.
- tx_ready low for 10 cycles with owner valid -> tx_valid=1, tx_data stable, req_ready[o]=0, burst_cnt unchanged; resume -> single transfer.
- Assert rst low mid-packet while owning, after 2 of 5 bytes -> grant=0, tx_valid=0 immediately (async); after release, requester 0 is granted first if valid.
- Single requester 2 sending two 1-byte packets back-to-back -> exactly one idle cycle (grant=0) between the two transfers.
